multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle control unit for the MIPS CPU. It replaces the single-cycle decoder with a finite-state sequencer that steps each instruction through IF/ID/EXE/MEM/WB. Each step issues the datapath strobes: PC write, IR load, register-file write, memory read/write, ALU and mux selects. It sits between the instruction register's opcode field and the existing datapath, which gains an IR and per-stage holding registers.

## Interface
- No parameters; opcode encodings below are fixed.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- op  in  6  opcode from IR[31:26]; stable from ID onward.
- zero  in  1  ALU zero flag, valid in EXE_BR.
- state  out  4  current state (debug/bench observation).
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read (1 = read).
- RegWre  out  1  register-file write enable.
- RegDst  out  2  write register: 00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  out  1  write data: 0 = PC+4, 1 = DB bus.
- ALUSrcA  out  1  1 = shamt, 0 = rs.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- ALUOp  out  3  000 add, 001 sub, 010 shift B left by A, 011 or, 100 and, 101 signed set-less-than.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- DBDataSrc  out  1  1 = memory data, 0 = ALU result.
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(sext(imm)<<2), 10 = jump target.

## Operation
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, ori 010010
  - sll 011000, slt 100110
  - sw 110000, lw 110001
  - beq 110100, bne 110101
  - j 111000, jal 111010
  - halt 111111
  - Any other opcode is illegal.
- States: IF 0000, ID 0001, EXE_AL 0010, WB_AL 0011, EXE_LS 0100, MEM 0101, WB_LD 0110, EXE_BR 0111, HALT 1000.
- Transitions:
  - IF → ID.
  - ID → EXE_AL for add/sub/addiu/and/ori/sll/slt.
  - ID → EXE_LS for lw/sw.
  - ID → EXE_BR for beq/bne.
  - ID → IF for j/jal/illegal.
  - ID → HALT for halt.
  - EXE_AL → WB_AL → IF.
  - EXE_LS → MEM.
  - MEM → WB_LD for lw; MEM → IF for sw.
  - WB_LD → IF.
  - EXE_BR → IF.
  - HALT → HALT until reset.
- Strobes, all 0 unless listed:
  - IF: IRWre=1, InsMemRW=1.
  - ID, j/jal: PCWre=1, PCSrc=10. jal also RegWre=1, RegDst=00, WrRegDSrc=0.
  - ID, illegal: PCWre=1, PCSrc=00 (executes as a NOP).
  - EXE_AL/EXE_LS/EXE_BR: ALU selects only.
  - WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00. RegDst=10 for add/sub/and/sll/slt, 01 for addiu/ori.
  - MEM: mRD=1 for lw; mWR=1, PCWre=1, PCSrc=00 for sw.
  - WB_LD: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, PCWre=1, PCSrc=00.
  - EXE_BR: PCWre=1. PCSrc=01 when (beq & zero) | (bne & ~zero), else 00.
  - HALT: all strobes 0.
- ALU selects, driven in every state after IF:
  - ALUOp: add for addiu/lw/sw; sub for sub/beq/bne; and; or for ori; shift for sll; slt for slt.
  - ALUSrcA=1 only for sll.
  - ALUSrcB=1 for addiu/ori/lw/sw.
  - ExtSel=0 only for ori.
- Outputs are combinational from state, op and zero; only state is registered.

## Timing
- State advances once per rising edge.
- Cycles per instruction: j/jal/illegal 2, beq/bne 3, R-type/addiu/ori/sw 4, lw 5.
- PCWre is high exactly once per instruction, in its final cycle, so the PC updates at that edge.
- IRWre is high only in IF; op must not be sampled in IF.
- zero is used only in EXE_BR, in the same cycle.
- Reset:
  - While reset=1, every strobe output is forced to 0.
  - The next edge loads state=IF (0000), including from HALT or mid-instruction.
  - An aborted instruction performs no register or memory write in its reset cycle.
- The first IF after reset deassertion asserts IRWre=1.

## Test plan
- reset high for 2 cycles, then op=000000 (add) → state sequence 0,1,2,3,0. WB_AL shows RegWre=1, RegDst=10, PCWre=1, PCSrc=00. All strobes 0 during reset.
- op=110001 (lw) → states 0,1,4,5,6,0. MEM: mRD=1, mWR=0. WB_LD: DBDataSrc=1, RegDst=01, RegWre=1. ALUOp=000, ALUSrcB=1, ExtSel=1 throughout.
- op=110100 (beq): with zero=1, EXE_BR gives PCSrc=01, PCWre=1. With zero=0, PCSrc=00. For bne (110101) the two cases are inverted.
- op=111010 (jal) → 2 cycles. ID: PCSrc=10, PCWre=1, RegWre=1, RegDst=00, WrRegDSrc=0.
- op=111111 (halt) → HALT (1000) held ≥10 cycles with all strobes 0. Then reset for 1 cycle → state=0000 and IRWre=1 on the next cycle.
- lw reaches MEM, reset asserted → mRD forced 0, next state 0000. Illegal op 001111 → 2-cycle NOP with PCWre=1, PCSrc=00, RegWre=0.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control sequencer.
// Steps each instruction through IF/ID/EXE/MEM/WB and issues datapath strobes.
module multi_cycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [3:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [3:0] S_IF     = 4'b0000;
    localparam logic [3:0] S_ID     = 4'b0001;
    localparam logic [3:0] S_EXE_AL = 4'b0010;
    localparam logic [3:0] S_WB_AL  = 4'b0011;
    localparam logic [3:0] S_EXE_LS = 4'b0100;
    localparam logic [3:0] S_MEM    = 4'b0101;
    localparam logic [3:0] S_WB_LD  = 4'b0110;
    localparam logic [3:0] S_EXE_BR = 4'b0111;
    localparam logic [3:0] S_HALT   = 4'b1000;

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic is_add, is_sub, is_addiu, is_and, is_ori, is_sll, is_slt;
    logic is_sw, is_lw, is_beq, is_bne, is_j, is_jal, is_halt;
    logic is_rd_alu, is_rt_alu, is_alu, is_ls, is_br, is_jmp;
    logic br_taken;

    assign is_add   = (op == OP_ADD);
    assign is_sub   = (op == OP_SUB);
    assign is_addiu = (op == OP_ADDIU);
    assign is_and   = (op == OP_AND);
    assign is_ori   = (op == OP_ORI);
    assign is_sll   = (op == OP_SLL);
    assign is_slt   = (op == OP_SLT);
    assign is_sw    = (op == OP_SW);
    assign is_lw    = (op == OP_LW);
    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = (op == OP_BNE);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign is_halt  = (op == OP_HALT);

    assign is_rd_alu = is_add | is_sub | is_and | is_sll | is_slt;
    assign is_rt_alu = is_addiu | is_ori;
    assign is_alu    = is_rd_alu | is_rt_alu;
    assign is_ls     = is_lw | is_sw;
    assign is_br     = is_beq | is_bne;
    assign is_jmp    = is_j | is_jal;
    assign br_taken  = (is_beq & zero) | (is_bne & ~zero);

    assign state = state_q;

    // State register; reset restarts fetch from any state.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // Next-state sequencing; unused encodings fall back to fetch.
    always_comb begin
        state_d = S_IF;
        unique case (state_q)
            S_IF:     state_d = S_ID;
            S_ID: begin
                if (is_alu)       state_d = S_EXE_AL;
                else if (is_ls)   state_d = S_EXE_LS;
                else if (is_br)   state_d = S_EXE_BR;
                else if (is_halt) state_d = S_HALT;
                else              state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    // Strobe and ALU-select decode; everything is held low during reset.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = 3'b000;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        if (!reset) begin
            if (state_q >= S_ID && state_q <= S_EXE_BR) begin
                ALUSrcA = is_sll;
                ALUSrcB = is_addiu | is_ori | is_ls;
                ExtSel  = ~is_ori;
                unique case (1'b1)
                    is_sub | is_br: ALUOp = 3'b001;
                    is_sll:         ALUOp = 3'b010;
                    is_ori:         ALUOp = 3'b011;
                    is_and:         ALUOp = 3'b100;
                    is_slt:         ALUOp = 3'b101;
                    default:        ALUOp = 3'b000;
                endcase
            end
            unique case (state_q)
                S_IF: begin
                    IRWre    = 1'b1;
                    InsMemRW = 1'b1;
                end
                S_ID: begin
                    if (is_jmp) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                        if (is_jal) begin
                            RegWre    = 1'b1;
                            RegDst    = 2'b00;
                            WrRegDSrc = 1'b0;
                        end
                    end else if (!(is_alu | is_ls | is_br | is_halt)) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b00;
                    end
                end
                S_WB_AL: begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b0;
                    PCWre     = 1'b1;
                    PCSrc     = 2'b00;
                    RegDst    = is_rt_alu ? 2'b01 : 2'b10;
                end
                S_MEM: begin
                    mRD = is_lw;
                    if (is_sw) begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                        PCSrc = 2'b00;
                    end
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    RegDst    = 2'b01;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                    PCSrc     = 2'b00;
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    PCSrc = br_taken ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control.
// Instruction-level model plus directed literal checks.
module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic [3:0] state;
    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc;
    logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    int n_chk = 0;
    int n_fail = 0;

    multi_cycle_control dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .state(state),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
        .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
        .PCSrc(PCSrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction classes: 0 rd-ALU, 1 rt-ALU, 2 lw, 3 sw, 4 branch,
    // 5 jump, 6 illegal, 7 halt.
    function automatic int cls_of(input logic [5:0] o);
        case (o)
            6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100110: return 0;
            6'b000010, 6'b010010: return 1;
            6'b110001: return 2;
            6'b110000: return 3;
            6'b110100, 6'b110101: return 4;
            6'b111000, 6'b111010: return 5;
            6'b111111: return 7;
            default: return 6;
        endcase
    endfunction

    int seq_tab[8][5] = '{
        '{0, 1, 2, 3, 0}, '{0, 1, 2, 3, 0}, '{0, 1, 4, 5, 6},
        '{0, 1, 4, 5, 0}, '{0, 1, 7, 0, 0}, '{0, 1, 0, 0, 0},
        '{0, 1, 0, 0, 0}, '{0, 1, 8, 8, 8}
    };
    int len_tab[8] = '{4, 4, 5, 4, 3, 2, 2, 100};

    int  k = 0;
    bit  started = 0;

    // Model: position within the current instruction.
    always @(posedge clk) begin
        if (reset) begin
            k = 0;
            started = 1;
        end else if (started) begin
            if (cls_of(op) == 7) k = (k < 2) ? k + 1 : 2;
            else k = (k + 1 == len_tab[cls_of(op)]) ? 0 : k + 1;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            int c, es, last;
            logic [12:0] es_v, act_v;
            logic [5:0]  ea_v, aa_v;
            logic e_pcw, e_reg, taken;
            logic [1:0] e_dst, e_src;
            int e_aop;
            c     = cls_of(op);
            es    = seq_tab[c][k];
            last  = (c != 7) && (k == len_tab[c] - 1);
            taken = (op == 6'b110100 && zero) || (op == 6'b110101 && !zero);
            e_pcw = last;
            e_src = !last ? 2'b00 : (c == 5) ? 2'b10 :
                    (c == 4 && taken) ? 2'b01 : 2'b00;
            e_reg = (es == 1 && op == 6'b111010) || es == 3 || es == 6;
            e_dst = (es == 3) ? ((c == 0) ? 2'b10 : 2'b01) :
                    (es == 6) ? 2'b01 : 2'b00;
            es_v = {e_pcw, es == 0, es == 0, e_reg, e_dst,
                    es == 3 || es == 6, es == 5 && c == 2,
                    es == 5 && c == 3, es == 6, e_src};
            if (reset) es_v = '0;
            act_v = {PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
                     mRD, mWR, DBDataSrc, PCSrc};
            chk("state", int'(state), reset ? int'(state) : es);
            if (!reset && started) chk("state_model", int'(state), es);
            chk("strobes", int'(act_v), int'(es_v));
            if (es >= 1 && es <= 7 && !reset) begin
                ea_v = {op == 6'b011000,
                        op == 6'b000010 || op == 6'b010010 || c == 2 || c == 3,
                        op != 6'b010010, 3'b000};
                aa_v = {ALUSrcA, ALUSrcB, ExtSel, 3'b000};
                chk("alu_sel", int'(aa_v), int'(ea_v));
                case (op)
                    6'b000000, 6'b000010, 6'b110000, 6'b110001: e_aop = 0;
                    6'b000001, 6'b110100, 6'b110101:            e_aop = 1;
                    6'b011000: e_aop = 2;
                    6'b010010: e_aop = 3;
                    6'b010000: e_aop = 4;
                    6'b100110: e_aop = 5;
                    default:   e_aop = -1;
                endcase
                if (e_aop >= 0) chk("aluop", int'(ALUOp), e_aop);
            end
            if (reset) chk("rst_aluop", int'({ALUSrcA, ALUSrcB, ExtSel, ALUOp}), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] o, input logic z, input int n);
        op = o;
        zero = z;
        repeat (n) step();
        chk("cpi_end_state", int'(state), 0);
    endtask

    initial begin
        reset = 1'b1;
        op = 6'b000000;
        zero = 1'b0;
        step();
        step();
        chk("rst_state", int'(state), 0);
        chk("rst_irwre", int'(IRWre), 0);
        chk("rst_pcwre", int'(PCWre), 0);
        reset = 1'b0;
        #1;
        chk("if_irwre", int'(IRWre), 1);
        // add: 0,1,2,3,0
        step(); chk("add_id", int'(state), 1);
        step(); chk("add_exe", int'(state), 2);
        step(); chk("add_wb", int'(state), 3);
        chk("add_regwre", int'(RegWre), 1);
        chk("add_regdst", int'(RegDst), 2);
        chk("add_pcwre", int'(PCWre), 1);
        chk("add_pcsrc", int'(PCSrc), 0);
        step(); chk("add_done", int'(state), 0);
        // lw: 0,1,4,5,6,0
        op = 6'b110001;
        step(); step(); chk("lw_exe", int'(state), 4);
        chk("lw_aluop", int'(ALUOp), 0);
        chk("lw_srcb", int'(ALUSrcB), 1);
        step(); chk("lw_mem", int'(state), 5);
        chk("lw_mrd", int'(mRD), 1);
        chk("lw_mwr", int'(mWR), 0);
        step(); chk("lw_wb", int'(state), 6);
        chk("lw_dbsrc", int'(DBDataSrc), 1);
        chk("lw_regdst", int'(RegDst), 1);
        step(); chk("lw_done", int'(state), 0);
        // branches
        op = 6'b110100; zero = 1'b1;
        step(); step(); chk("beq_t_pcsrc", int'(PCSrc), 1);
        chk("beq_t_pcwre", int'(PCWre), 1);
        step();
        op = 6'b110100; zero = 1'b0;
        step(); step(); chk("beq_n_pcsrc", int'(PCSrc), 0);
        step();
        run(6'b110101, 1'b1, 3);
        op = 6'b110101; zero = 1'b0;
        step(); step(); chk("bne_t_pcsrc", int'(PCSrc), 1);
        step();
        // jal
        op = 6'b111010;
        step(); chk("jal_pcsrc", int'(PCSrc), 2);
        chk("jal_regwre", int'(RegWre), 1);
        chk("jal_regdst", int'(RegDst), 0);
        chk("jal_wrsrc", int'(WrRegDSrc), 0);
        step(); chk("jal_done", int'(state), 0);
        // remaining opcodes via the model
        run(6'b111000, 1'b0, 2);
        run(6'b000001, 1'b1, 4);
        run(6'b000010, 1'b0, 4);
        run(6'b010000, 1'b0, 4);
        run(6'b010010, 1'b0, 4);
        run(6'b011000, 1'b0, 4);
        run(6'b100110, 1'b0, 4);
        run(6'b110000, 1'b0, 4);
        // illegal NOP
        op = 6'b001111;
        step(); chk("ill_pcwre", int'(PCWre), 1);
        chk("ill_pcsrc", int'(PCSrc), 0);
        chk("ill_regwre", int'(RegWre), 0);
        step(); chk("ill_done", int'(state), 0);
        // halt held, then reset
        op = 6'b111111;
        step(); step(); chk("halt_state", int'(state), 8);
        repeat (10) step();
        chk("halt_hold", int'(state), 8);
        chk("halt_pcwre", int'(PCWre), 0);
        reset = 1'b1;
        step(); chk("halt_rst_state", int'(state), 0);
        reset = 1'b0;
        #1;
        chk("halt_rst_irwre", int'(IRWre), 1);
        // abort lw in MEM
        op = 6'b110001;
        step(); step(); step(); chk("abort_mem", int'(state), 5);
        reset = 1'b1;
        #1;
        chk("abort_mrd", int'(mRD), 0);
        step(); chk("abort_state", int'(state), 0);
        reset = 1'b0;
        run(6'b000000, 1'b0, 4);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
